// File: rtl/b2_halfsubtractor_if.sv
// Operand/result bundle for the borrow-chain half subtractor.
// The subtractor takes the slave side; its driver takes the master side.
interface b2_halfsubtractor_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] x;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             vld_r;
  logic             bout_seen;

  modport master (
    output x, bin, en, clr,
    input  d, bout, d_r, bout_r, vld_r, bout_seen
  );

  modport slave (
    input  x, bin, en, clr,
    output d, bout, d_r, bout_r, vld_r, bout_seen
  );
endinterface

// File: rtl/b2_halfsubtractor.sv
// Borrow-chain half subtractor: d = x - bin (mod 2^WIDTH), bout = borrow-out.
// The combinational result feeds down-counter datapaths directly. A registered
// copy with a one-cycle valid pulse and a sticky borrow flag serves pipelined
// consumers.
module b2_halfsubtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                clock,
  input  logic                reset_,
  b2_halfsubtractor_if.slave  bus
);

  logic [WIDTH-1:0] diff;
  logic             chain_b;
  logic             bout_c;

  logic [WIDTH-1:0] d_r_q, d_r_d;
  logic             bout_r_q, bout_r_d;
  logic             vld_r_q, vld_r_d;
  logic             bout_seen_q, bout_seen_d;

  // Ripple borrow from bit 0 upward; the borrow surviving the top bit is bout.
  always_comb begin
    diff    = '0;
    chain_b = bus.bin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff[i] = bus.x[i] ^ chain_b;
      chain_b = ~bus.x[i] & chain_b;
    end
    bout_c = chain_b;
  end

  assign bus.d    = diff;
  assign bus.bout = bout_c;

  // Capture on en, otherwise hold; a new borrow capture wins over clr.
  always_comb begin
    d_r_d       = d_r_q;
    bout_r_d    = bout_r_q;
    vld_r_d     = 1'b0;
    bout_seen_d = bout_seen_q;
    if (bus.en) begin
      d_r_d    = diff;
      bout_r_d = bout_c;
      vld_r_d  = 1'b1;
    end
    if (bus.clr) begin
      bout_seen_d = 1'b0;
    end
    if (bus.en && bout_c) begin
      bout_seen_d = 1'b1;
    end
  end

  // Registered stage; reset discards any capture requested in the same cycle.
  always_ff @(posedge clock) begin
    if (reset_) begin
      d_r_q       <= '0;
      bout_r_q    <= 1'b0;
      vld_r_q     <= 1'b0;
      bout_seen_q <= 1'b0;
    end else begin
      d_r_q       <= d_r_d;
      bout_r_q    <= bout_r_d;
      vld_r_q     <= vld_r_d;
      bout_seen_q <= bout_seen_d;
    end
  end

  assign bus.d_r       = d_r_q;
  assign bus.bout_r    = bout_r_q;
  assign bus.vld_r     = vld_r_q;
  assign bus.bout_seen = bout_seen_q;

endmodule

// File: tb/tb_b2_halfsubtractor.sv
// Self-checking bench for b2_halfsubtractor at WIDTH=1 and WIDTH=4.
module tb_b2_halfsubtractor;

  logic clock;
  logic reset_;

  int n_tests;
  int n_fail;

  b2_halfsubtractor_if #(.WIDTH(1)) if1 ();
  b2_halfsubtractor_if #(.WIDTH(4)) if4 ();

  b2_halfsubtractor #(.WIDTH(1)) u_dut1 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (if1.slave)
  );

  b2_halfsubtractor #(.WIDTH(4)) u_dut4 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (if4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state of the registered stage (WIDTH=4 instance).
  int m_dr;
  int m_br;
  int m_vld;
  int m_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: difference modulo 2^w, borrow when x < bin.
  function automatic int ref_diff(input int xv, input int bv, input int w);
    int t;
    t = xv - bv;
    if (t < 0) t = t + (1 << w);
    return t;
  endfunction

  function automatic int ref_borrow(input int xv, input int bv);
    return (xv < bv) ? 1 : 0;
  endfunction

  task automatic comb4(input string tag, input int xv, input int bv, input int ed, input int eb);
    if4.x   = 4'(xv);
    if4.bin = bv[0];
    #1;
    check_eq({tag, "_d"},    32'(if4.d),    32'(ed));
    check_eq({tag, "_bout"}, 32'(if4.bout), 32'(eb));
  endtask

  task automatic check_reg4(input string tag, input int ed, input int eb, input int ev, input int es);
    check_eq({tag, "_d_r"},       32'(if4.d_r),       32'(ed));
    check_eq({tag, "_bout_r"},    32'(if4.bout_r),    32'(eb));
    check_eq({tag, "_vld_r"},     32'(if4.vld_r),     32'(ev));
    check_eq({tag, "_bout_seen"}, 32'(if4.bout_seen), 32'(es));
  endtask

  initial begin
    int exp_d1 [4];
    int exp_b1 [4];
    n_tests = 0;
    n_fail  = 0;
    exp_d1 = '{0, 1, 1, 0};
    exp_b1 = '{0, 1, 0, 0};

    reset_  = 1'b1;
    if1.x   = '0; if1.bin = 1'b0; if1.en = 1'b0; if1.clr = 1'b0;
    if4.x   = '0; if4.bin = 1'b0; if4.en = 1'b0; if4.clr = 1'b0;

    // Reset state for both widths
    repeat (2) @(posedge clock);
    #1;
    check_reg4("rst4", 0, 0, 0, 0);
    check_eq("rst1_d_r",       32'(if1.d_r),       32'd0);
    check_eq("rst1_bout_r",    32'(if1.bout_r),    32'd0);
    check_eq("rst1_vld_r",     32'(if1.vld_r),     32'd0);
    check_eq("rst1_bout_seen", 32'(if1.bout_seen), 32'd0);
    @(negedge clock);
    reset_ = 1'b0;

    // WIDTH=1 exhaustive truth table, index = {x,bin}
    for (int i = 0; i < 4; i++) begin
      if1.x   = 1'(i >> 1);
      if1.bin = i[0];
      #1;
      check_eq($sformatf("w1_tt%0d_d", i),    32'(if1.d),    32'(exp_d1[i]));
      check_eq($sformatf("w1_tt%0d_bout", i), 32'(if1.bout), 32'(exp_b1[i]));
    end

    // WIDTH=4 wrap-around and mid-range borrow
    comb4("w4_wrap", 0, 1, 15, 1);
    comb4("w4_x8",   8, 1, 7,  0);
    // bin=0 passes x through with no borrow
    for (int xv = 0; xv < 16; xv++) begin
      comb4($sformatf("w4_pass%0d", xv), xv, 0, xv, 0);
    end

    // Capture a borrow, then hold
    @(negedge clock);
    if4.x = 4'h0; if4.bin = 1'b1; if4.en = 1'b1;
    @(posedge clock); #1;
    check_reg4("cap", 15, 1, 1, 1);
    @(negedge clock);
    if4.en = 1'b0; if4.x = 4'h5; if4.bin = 1'b0;
    @(posedge clock); #1;
    check_reg4("hold", 15, 1, 0, 1);

    // clr clears the sticky flag; set wins over clr
    @(negedge clock);
    if4.clr = 1'b1;
    @(posedge clock); #1;
    check_reg4("clr", 15, 1, 0, 0);
    @(negedge clock);
    if4.clr = 1'b1; if4.en = 1'b1; if4.x = 4'h0; if4.bin = 1'b1;
    @(posedge clock); #1;
    check_reg4("setclr", 15, 1, 1, 1);

    // Reset discards a simultaneous capture
    @(negedge clock);
    if4.clr = 1'b0; reset_ = 1'b1; if4.en = 1'b1; if4.x = 4'h3; if4.bin = 1'b1;
    @(posedge clock); #1;
    check_reg4("rst_en", 0, 0, 0, 0);
    @(negedge clock);
    reset_ = 1'b0; if4.en = 1'b0;

    // Randomized run against the reference model
    m_dr = 0; m_br = 0; m_vld = 0; m_seen = 0;
    @(posedge clock); #1;
    for (int it = 0; it < 400; it++) begin
      int xv, bv, env, clv, rv, ed, eb, x1, b1;
      @(negedge clock);
      xv  = int'($urandom_range(15, 0));
      bv  = int'($urandom_range(1, 0));
      env = int'($urandom_range(1, 0));
      clv = ($urandom_range(7, 0) == 0) ? 1 : 0;
      rv  = ($urandom_range(24, 0) == 0) ? 1 : 0;
      x1  = int'($urandom_range(1, 0));
      b1  = int'($urandom_range(1, 0));
      reset_  = rv[0];
      if4.x   = 4'(xv);
      if4.bin = bv[0];
      if4.en  = env[0];
      if4.clr = clv[0];
      if1.x   = 1'(x1);
      if1.bin = b1[0];
      ed = ref_diff(xv, bv, 4);
      eb = ref_borrow(xv, bv);
      #1;
      check_eq("rnd_d",     32'(if4.d),    32'(ed));
      check_eq("rnd_bout",  32'(if4.bout), 32'(eb));
      check_eq("rnd1_d",    32'(if1.d),    32'(ref_diff(x1, b1, 1)));
      check_eq("rnd1_bout", 32'(if1.bout), 32'(ref_borrow(x1, b1)));
      @(posedge clock);
      if (rv != 0) begin
        m_dr = 0; m_br = 0; m_vld = 0; m_seen = 0;
      end else begin
        if (env != 0) begin
          m_dr = ed; m_br = eb; m_vld = 1;
        end else begin
          m_vld = 0;
        end
        if (env != 0 && eb != 0) m_seen = 1;
        else if (clv != 0)       m_seen = 0;
      end
      #1;
      check_reg4("rnd", m_dr, m_br, m_vld, m_seen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
